// File: rtl/lcd_cmd_sequencer.sv
// HD44780 command sequencer driving a PCF8574 I2C backpack in 4-bit mode.
// Runs the power-up delay and init sequence, then accepts command/data bytes
// and turns each into EN-strobed nibble writes for an external I2C master.
module lcd_cmd_sequencer #(
  parameter int unsigned POWERUP_CYC   = 2000000,
  parameter int unsigned NIB_WAIT_CYC  = 250000,
  parameter int unsigned CMD_WAIT_CYC  = 2500,
  parameter int unsigned SLOW_WAIT_CYC = 100000,
  parameter logic        BACKLIGHT     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_byte,
  output logic       i2c_start,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       init_done,
  output logic       err
);

  // A zero count is treated as one cycle; counters hold "last cycle" values.
  localparam int unsigned PWR_EFF  = (POWERUP_CYC   == 0) ? 1 : POWERUP_CYC;
  localparam int unsigned NIB_EFF  = (NIB_WAIT_CYC  == 0) ? 1 : NIB_WAIT_CYC;
  localparam int unsigned CMD_EFF  = (CMD_WAIT_CYC  == 0) ? 1 : CMD_WAIT_CYC;
  localparam int unsigned SLOW_EFF = (SLOW_WAIT_CYC == 0) ? 1 : SLOW_WAIT_CYC;

  localparam logic [31:0] PWR_LAST  = 32'(PWR_EFF - 1);
  localparam logic [31:0] NIB_LAST  = 32'(NIB_EFF - 1);
  localparam logic [31:0] CMD_LAST  = 32'(CMD_EFF - 1);
  localparam logic [31:0] SLOW_LAST = 32'(SLOW_EFF - 1);

  localparam logic [7:0] FIRST_INIT_BYTE = 8'h30;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT_I2C,
    S_DELAY,
    S_ERROR
  } state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] dly_last_q;
  logic [2:0]  step_q;
  logic [1:0]  wr_idx_q;
  logic [7:0]  byte_q;
  logic        rs_q;
  logic        nib_mode_q;
  logic        start_q;
  logic [7:0]  data_q;
  logic        ready_q;
  logic        init_done_q;
  logic        err_q;

  logic [1:0]  wr_nxt_d;
  logic        last_wr_d;
  logic [31:0] dly_sel_d;
  logic [2:0]  step_nxt_d;
  logic [7:0]  step_byte_d;
  logic [7:0]  wr_cur_data_d;
  logic [7:0]  wr_nxt_data_d;
  logic [7:0]  acc_data_d;
  logic [7:0]  step_data_d;
  logic [7:0]  pwr_data_d;
  state_t      hold_state_d;

  // Expander byte {D7..D4, BL, EN, RW, RS}; writes 0/1 carry the high nibble,
  // 2/3 the low nibble, and even-numbered writes raise EN.
  function automatic logic [7:0] exp_byte(input logic [7:0] b, input logic rs,
                                          input logic [1:0] idx);
    logic [3:0] nib;
    nib = idx[1] ? b[3:0] : b[7:4];
    return {nib, BACKLIGHT, ~idx[0], 1'b0, rs};
  endfunction

  // Init steps 0-3 are single nibbles (held in the high nibble), 4-7 full bytes.
  function automatic logic [7:0] init_byte(input logic [2:0] step);
    logic [7:0] b;
    case (step)
      3'd0, 3'd1, 3'd2: b = 8'h30;
      3'd3:             b = 8'h20;
      3'd4:             b = 8'h28;
      3'd5:             b = 8'h0C;
      3'd6:             b = 8'h06;
      default:          b = 8'h01;
    endcase
    return b;
  endfunction

  // Next-write data, post-byte delay selection and init step bookkeeping.
  always_comb begin
    wr_nxt_d      = wr_idx_q + 2'd1;
    last_wr_d     = nib_mode_q ? (wr_idx_q == 2'd1) : (wr_idx_q == 2'd3);
    step_nxt_d    = step_q + 3'd1;
    step_byte_d   = init_byte(step_nxt_d);
    wr_cur_data_d = exp_byte(byte_q, rs_q, wr_idx_q);
    wr_nxt_data_d = exp_byte(byte_q, rs_q, wr_nxt_d);
    acc_data_d    = exp_byte(req_byte, req_rs, 2'd0);
    step_data_d   = exp_byte(step_byte_d, 1'b0, 2'd0);
    pwr_data_d    = exp_byte(FIRST_INIT_BYTE, 1'b0, 2'd0);
    hold_state_d  = init_done_q ? S_ISSUE : S_INIT;
    if (nib_mode_q) begin
      dly_sel_d = NIB_LAST;
    end else if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03)) begin
      dly_sel_d = SLOW_LAST;
    end else begin
      dly_sel_d = CMD_LAST;
    end
  end

  // Main sequencer. Whenever a write is due and the bus is free, i2c_start
  // and i2c_data are registered on that same edge; otherwise the FSM parks
  // in INIT/ISSUE until i2c_busy drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_POWERUP;
      cnt_q       <= '0;
      dly_last_q  <= '0;
      step_q      <= '0;
      wr_idx_q    <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      nib_mode_q  <= 1'b0;
      start_q     <= 1'b0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_POWERUP: begin
          if (cnt_q == PWR_LAST) begin
            cnt_q      <= '0;
            step_q     <= '0;
            byte_q     <= FIRST_INIT_BYTE;
            rs_q       <= 1'b0;
            nib_mode_q <= 1'b1;
            wr_idx_q   <= '0;
            if (!i2c_busy) begin
              start_q <= 1'b1;
              data_q  <= pwr_data_d;
              state_q <= S_WAIT_I2C;
            end else begin
              state_q <= S_INIT;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        S_INIT, S_ISSUE: begin
          if (!i2c_busy) begin
            start_q <= 1'b1;
            data_q  <= wr_cur_data_d;
            state_q <= S_WAIT_I2C;
          end
        end

        S_IDLE: begin
          if (req_valid && ready_q) begin
            ready_q    <= 1'b0;
            byte_q     <= req_byte;
            rs_q       <= req_rs;
            nib_mode_q <= 1'b0;
            wr_idx_q   <= '0;
            if (!i2c_busy) begin
              start_q <= 1'b1;
              data_q  <= acc_data_d;
              state_q <= S_WAIT_I2C;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end

        S_WAIT_I2C: begin
          if (i2c_done) begin
            if (i2c_nack) begin
              err_q   <= 1'b1;
              state_q <= S_ERROR;
            end else if (last_wr_d) begin
              cnt_q      <= '0;
              dly_last_q <= dly_sel_d;
              state_q    <= S_DELAY;
            end else begin
              wr_idx_q <= wr_nxt_d;
              if (!i2c_busy) begin
                start_q <= 1'b1;
                data_q  <= wr_nxt_data_d;
              end else begin
                state_q <= hold_state_d;
              end
            end
          end
        end

        S_DELAY: begin
          if (cnt_q == dly_last_q) begin
            cnt_q <= '0;
            if (init_done_q || step_q == 3'd7) begin
              init_done_q <= 1'b1;
              ready_q     <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              step_q     <= step_nxt_d;
              byte_q     <= step_byte_d;
              rs_q       <= 1'b0;
              nib_mode_q <= ~step_nxt_d[2];
              wr_idx_q   <= '0;
              if (!i2c_busy) begin
                start_q <= 1'b1;
                data_q  <= step_data_d;
                state_q <= S_WAIT_I2C;
              end else begin
                state_q <= S_INIT;
              end
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        S_ERROR: begin
          ready_q <= 1'b0;
          err_q   <= 1'b1;
        end

        default: begin
          state_q <= S_POWERUP;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign i2c_start = start_q;
  assign i2c_data  = data_q;
  assign init_done = init_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: I2C master model with fixed 5-cycle transfers,
// table of byte requests with expected expander writes and delays, plus
// hand-written init, back-to-back, stale-done, mid-byte reset and NACK cases.
module tb_lcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_byte = '0;
  logic       req_ready, i2c_start, init_done, err;
  logic [7:0] i2c_data;
  logic       i2c_busy, i2c_done, i2c_nack;

  logic mdl_busy = 1'b0, mdl_done = 1'b0, mdl_nack = 1'b0;
  logic inj_done = 1'b0, inj_nack = 1'b0;
  assign i2c_busy = mdl_busy;
  assign i2c_done = mdl_done | inj_done;
  assign i2c_nack = mdl_nack | inj_nack;

  int checks = 0, errors = 0, cyc = 0;
  int mdl_cnt = 0, xfer_cnt = 0, nack_at = -1, hold_viol = 0;
  logic       hold_trk = 1'b0;
  logic [7:0] hold_dat = '0;
  logic [7:0] st_dat[$];
  int         st_cyc[$];

  typedef struct {
    logic       rs;
    logic [7:0] b;
    logic [7:0] w0, w1, w2, w3;
    int         dly;
  } vec_t;
  vec_t       v[8];
  logic [7:0] init_exp[24];

  lcd_cmd_sequencer #(
    .POWERUP_CYC(20),
    .NIB_WAIT_CYC(10),
    .CMD_WAIT_CYC(4),
    .SLOW_WAIT_CYC(8),
    .BACKLIGHT(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_byte(req_byte),
    .i2c_start(i2c_start), .i2c_data(i2c_data), .i2c_busy(i2c_busy),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // I2C master model + write monitor: done pulses 5 cycles after each start.
  always @(negedge clk) begin
    mdl_done = 1'b0;
    mdl_nack = 1'b0;
    if (hold_trk && !reset && i2c_data !== hold_dat) hold_viol++;
    if (reset) hold_trk = 1'b0;
    if (i2c_start) begin
      st_dat.push_back(i2c_data);
      st_cyc.push_back(cyc);
      mdl_busy = 1'b1;
      mdl_cnt  = 5;
      hold_trk = 1'b1;
      hold_dat = i2c_data;
    end else if (mdl_cnt != 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mdl_busy = 1'b0;
        mdl_done = 1'b1;
        xfer_cnt++;
        mdl_nack = (xfer_cnt == nack_at);
        hold_trk = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k;
    k = 0;
    while (st_dat.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("start_wait", 32'(st_dat.size() >= n), 1);
  endtask

  task automatic wait_ready(input int budget, output int rc);
    int k;
    k = 0;
    while (!req_ready && k < budget) begin
      tick();
      k++;
    end
    chk("ready_wait", 32'(req_ready), 1);
    rc = cyc;
  endtask

  task automatic wait_init(input int budget);
    int k;
    k = 0;
    while (!init_done && k < budget) begin
      tick();
      k++;
    end
    chk("init_done_wait", 32'(init_done), 1);
  endtask

  task automatic clear_log();
    st_dat.delete();
    st_cyc.delete();
  endtask

  function automatic int init_gap(input int i);
    if ((i % 2) == 1 && i <= 7) return 16;
    if (i == 11 || i == 15 || i == 19) return 10;
    return 6;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, rc, init_cyc;

    v[0] = '{1'b1, 8'h48, 8'h4D, 8'h49, 8'h8D, 8'h89, 4};
    v[1] = '{1'b0, 8'h01, 8'h0C, 8'h08, 8'h1C, 8'h18, 8};
    v[2] = '{1'b0, 8'h80, 8'h8C, 8'h88, 8'h0C, 8'h08, 4};
    v[3] = '{1'b0, 8'h02, 8'h0C, 8'h08, 8'h2C, 8'h28, 8};
    v[4] = '{1'b0, 8'h03, 8'h0C, 8'h08, 8'h3C, 8'h38, 8};
    v[5] = '{1'b0, 8'h04, 8'h0C, 8'h08, 8'h4C, 8'h48, 4};
    v[6] = '{1'b1, 8'h01, 8'h0D, 8'h09, 8'h1D, 8'h19, 4};
    v[7] = '{1'b1, 8'hFF, 8'hFD, 8'hF9, 8'hFD, 8'hF9, 4};
    init_exp = '{8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
                 8'h2C, 8'h28, 8'h8C, 8'h88,
                 8'h0C, 8'h08, 8'hCC, 8'hC8,
                 8'h0C, 8'h08, 8'h6C, 8'h68,
                 8'h0C, 8'h08, 8'h1C, 8'h18};

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_start", 32'(i2c_start), 0);
    chk("rst_data", 32'(i2c_data), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_err", 32'(err), 0);

    // Power-up delay and init sequence
    reset = 1'b0;
    c0 = cyc;
    clear_log();
    wait_starts(1, 60);
    if (st_cyc.size() >= 1) chk("powerup_delay", 32'(st_cyc[0] - c0), 20);
    wait_init(3000);
    init_cyc = cyc;
    chk("init_write_count", 32'(st_dat.size()), 24);
    if (st_dat.size() == 24) begin
      for (int i = 0; i < 24; i++) chk("init_data", 32'(st_dat[i]), 32'(init_exp[i]));
      for (int i = 0; i < 23; i++) chk("init_gap", 32'(st_cyc[i+1] - st_cyc[i]), 32'(init_gap(i)));
      chk("init_done_timing", 32'(init_cyc - st_cyc[23]), 14);
    end
    chk("init_ready", 32'(req_ready), 1);
    chk("init_err", 32'(err), 0);

    // Table of single requests
    for (int i = 0; i < 8; i++) begin
      clear_log();
      req_valid = 1'b1;
      req_rs    = v[i].rs;
      req_byte  = v[i].b;
      chk("ready_before", 32'(req_ready), 1);
      tick();
      req_valid = 1'b0;
      req_rs    = ~v[i].rs;
      req_byte  = ~v[i].b;
      chk("ready_drop", 32'(req_ready), 0);
      chk("start_after_accept", 32'(i2c_start), 1);
      wait_ready(200, rc);
      chk("write_count", 32'(st_dat.size()), 4);
      if (st_dat.size() == 4) begin
        chk("wr0", 32'(st_dat[0]), 32'(v[i].w0));
        chk("wr1", 32'(st_dat[1]), 32'(v[i].w1));
        chk("wr2", 32'(st_dat[2]), 32'(v[i].w2));
        chk("wr3", 32'(st_dat[3]), 32'(v[i].w3));
        chk("post_delay", 32'(rc - st_cyc[3] - 6), 32'(v[i].dly));
      end
    end

    // Back-to-back: request held valid through DELAY
    clear_log();
    req_valid = 1'b1;
    req_rs    = 1'b0;
    req_byte  = 8'h80;
    tick();
    req_rs    = 1'b1;
    req_byte  = 8'h48;
    wait_starts(5, 100);
    req_valid = 1'b0;
    if (st_dat.size() >= 5) begin
      chk("b2b_gap", 32'(st_cyc[4] - st_cyc[3]), 11);
      chk("b2b_first", 32'(st_dat[4]), 8'h4D);
    end
    wait_ready(200, rc);
    chk("b2b_writes", 32'(st_dat.size()), 8);
    if (st_dat.size() == 8) chk("b2b_last", 32'(st_dat[7]), 8'h89);

    // Stray done/nack while IDLE is ignored
    clear_log();
    inj_done = 1'b1;
    inj_nack = 1'b1;
    tick();
    inj_done = 1'b0;
    inj_nack = 1'b0;
    repeat (3) tick();
    chk("idle_done_err", 32'(err), 0);
    chk("idle_done_ready", 32'(req_ready), 1);
    chk("idle_done_nostart", 32'(st_dat.size()), 0);

    // Reset between the 2nd and 3rd write of a byte
    clear_log();
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_byte  = 8'h48;
    tick();
    req_valid = 1'b0;
    wait_starts(2, 50);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_init_done", 32'(init_done), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    chk("midrst_start", 32'(i2c_start), 0);
    chk("midrst_data", 32'(i2c_data), 0);
    reset = 1'b0;
    c0 = cyc;
    clear_log();
    tick();
    tick();
    inj_done = 1'b1;
    inj_nack = 1'b1;
    tick();
    inj_done = 1'b0;
    inj_nack = 1'b0;
    wait_starts(1, 60);
    if (st_cyc.size() >= 1) begin
      chk("midrst_powerup", 32'(st_cyc[0] - c0), 20);
      chk("midrst_first", 32'(st_dat[0]), 8'h3C);
    end
    chk("midrst_stale_err", 32'(err), 0);
    wait_init(3000);

    // NACK on the 2nd done of a byte
    nack_at = xfer_cnt + 2;
    clear_log();
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_byte  = 8'h41;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 60 && !err; k++) tick();
    chk("nack_err", 32'(err), 1);
    req_valid = 1'b1;
    repeat (20) tick();
    chk("nack_writes", 32'(st_dat.size()), 2);
    if (st_dat.size() >= 2) begin
      chk("nack_wr0", 32'(st_dat[0]), 8'h4D);
      chk("nack_wr1", 32'(st_dat[1]), 8'h49);
    end
    chk("nack_ready", 32'(req_ready), 0);
    chk("nack_start", 32'(i2c_start), 0);
    chk("nack_sticky", 32'(err), 1);
    req_valid = 1'b0;

    // Only reset clears the error
    reset = 1'b1;
    tick();
    chk("rst_clears_err", 32'(err), 0);
    chk("rst_clears_init", 32'(init_done), 0);
    reset = 1'b0;
    tick();

    chk("data_hold", 32'(hold_viol), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

Interface
REQ-001 Parameter POWERUP_CYC, default 2000000, power-up delay before init in clk cycles (40 ms at 50 MHz).
REQ-002 Parameter NIB_WAIT_CYC, default 250000, delay after each init-only nibble.
REQ-003 Parameter CMD_WAIT_CYC, default 2500, delay after a normal command or data byte.
REQ-004 Parameter SLOW_WAIT_CYC, default 100000, delay after a clear (0x01) or home (0x02) command.
REQ-005 Parameter BACKLIGHT, default 1, value driven on the PCF8574 P3 (BL) bit.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  1  a byte request is present.
REQ-009 req_ready  out  1  the block can accept a request.
REQ-010 req_rs  in  1  0 = command, 1 = character data.
REQ-011 req_byte  in  8  byte for the HD44780.
REQ-012 i2c_start  out  1  one-cycle pulse telling the I2C master to write i2c_data.
REQ-013 i2c_data  out  8  expander byte {D7..D4, BL, EN, RW, RS}.
REQ-014 i2c_busy  in  1  the I2C master is transferring.
REQ-015 i2c_done  in  1  one-cycle pulse when the transfer ends.
REQ-016 i2c_nack  in  1  qualifies i2c_done; high means the slave did not acknowledge.
REQ-017 init_done  out  1  the init sequence has completed.
REQ-018 err  out  1  sticky NACK error flag.

Function
REQ-019 States: POWERUP, INIT, IDLE, ISSUE, WAIT_I2C, DELAY, ERROR.
REQ-020 POWERUP lasts exactly POWERUP_CYC cycles, then enters INIT.
- A parameter value of 0 behaves as 1.
- Delay counters are at least 24 bits wide.
REQ-021 INIT sends single nibbles 0x3, 0x3, 0x3, 0x2, each followed by a NIB_WAIT_CYC delay.
- It then sends full commands 0x28, 0x0C, 0x06, 0x01, each followed by its normal post-byte delay.
- All init writes use RS=0.
REQ-022 Every nibble is two expander writes: first with EN=1, then with EN=0.
- A full byte is four writes: high nibble EN=1, high nibble EN=0, low nibble EN=1, low nibble EN=0.
- RW is always 0; BL = BACKLIGHT.
REQ-023 After the last init delay, init_done is set to 1 and stays 1 until reset; the block enters IDLE.
REQ-024 req_ready = 1 only in IDLE with init_done = 1 and err = 0.
REQ-025 Handshake:
- Accept on req_valid && req_ready; capture req_rs and req_byte.
- req_ready drops the following cycle.
- req_byte and req_rs are don't-care after acceptance.
REQ-026 ISSUE pulses i2c_start for one cycle, only in a cycle where i2c_busy = 0; otherwise it holds.
- The first i2c_start comes the cycle after acceptance when i2c_busy = 0.
REQ-027 i2c_data is updated in the cycle i2c_start pulses and held stable until the matching i2c_done.
REQ-028 WAIT_I2C waits for i2c_done.
- i2c_done with i2c_nack = 1 goes to ERROR.
- Otherwise the block moves to the next write, or to DELAY after the 4th write (2nd write for init nibbles).
REQ-029 The post-byte delay is SLOW_WAIT_CYC if RS=0 and byte is 0x01, 0x02 or 0x03; otherwise it is CMD_WAIT_CYC.
- DELAY lasts exactly the selected count, then returns to IDLE (or the next init step).
REQ-030 i2c_done or i2c_nack outside WAIT_I2C is ignored.
- req_valid outside IDLE is ignored and is not queued.
REQ-031 ERROR sets err = 1 and forces req_ready = 0 and i2c_start = 0; only reset leaves ERROR.
REQ-032 Back-to-back requests: a request held valid during DELAY is accepted in the first IDLE cycle.

Reset
REQ-033 When reset = 1 at a clock edge, the next state is POWERUP with these values:
- i2c_start = 0, i2c_data = 0x00, req_ready = 0, init_done = 0, err = 0, all counters = 0.
REQ-034 Reset in the middle of any operation abandons it and reruns the full POWERUP and INIT sequence.
- Stale i2c_done pulses after reset are ignored.

Verification
REQ-035 Bench parameters: POWERUP_CYC=20, NIB_WAIT_CYC=10, CMD_WAIT_CYC=4, SLOW_WAIT_CYC=8, BACKLIGHT=1. The I2C model completes each transfer 5 cycles after start.
REQ-036 Init, after reset release:
- First i2c_start exactly 20 cycles later, with data 0x3C, then 0x38.
- Writes 0x3C, 0x38 repeated for 3 nibbles, then 0x2C, 0x28.
- Then 0x28, 0x0C, 0x06, 0x01 as 4 writes each.
- init_done rises after the final 8-cycle delay.
REQ-037 Data write:
- Accept RS=1, byte 0x48 ('H').
- Expect writes 0x4D, 0x49, 0x8D, 0x89.
- Expect a 4-cycle delay, then req_ready = 1.
REQ-038 Clear timing: command 0x01 produces a SLOW delay of 8 cycles; command 0x80 produces a delay of 4 cycles.
REQ-039 NACK:
- Assert i2c_nack with the 2nd i2c_done of a byte.
- Expect err = 1, no further i2c_start, req_ready = 0 until reset.
REQ-040 Reset between the 2nd and 3rd write of a byte:
- No further i2c_start for 20 cycles.
- init_done = 0.
- The init sequence restarts at 0x3C.
- An injected stale i2c_done is ignored.
